lcd_line_formatter: RTL and testbench
=====================================

# lcd_line_formatter

Downstream display stage of the mini CPU. Captures the opcode, register index and 16-bit result that the CPU hands over on its LCD start pulse. Converts the signed value to decimal with an iterative double-dabble engine. Streams the 32 ASCII characters of a 16x2 screen image, one per valid/ready handshake, to the LCD byte writer.

## Interface

Parameters:
- none

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; operands sampled on the same edge
- `opcode`  in  3  0 LOAD, 1 ADD, 2 ADDI, 3 SUB, 4 SUBI, 5 MUL, 6 CLEAR, 7 DISPLAY
- `reg_idx`  in  4  register number shown on line 2
- `value`  in  16  two's-complement value shown on line 2
- `char_ready`  in  1  consumer accepts current character
- `char_valid`  out  1  `char_data`/`char_pos` valid
- `char_data`  out  8  ASCII character
- `char_pos`  out  5  screen position; 0-15 line 1, 16-31 line 2
- `busy`  out  1  request in progress; `start` ignored while high
- `done`  out  1  one-cycle pulse after the last character is accepted

## Operation

- States: IDLE, CONVERT, STREAM, DONE.
- IDLE:
  - `start`=1 latches `opcode`, `reg_idx`, `value`.
  - Computes sign = `value`[15] and magnitude = sign ? −`value` : `value`, as a 16-bit unsigned quantity, so 0x8000 gives 32768.
  - Clears the 20-bit BCD register and the iteration counter, then moves to CONVERT.
- CONVERT:
  - One double-dabble iteration per cycle: add 3 to every BCD nibble ≥5, then shift {BCD, magnitude} left by 1.
  - Exactly 16 iterations, then go to STREAM with `char_pos`=0.
- STREAM:
  - `char_valid`=1.
  - On `char_valid`&&`char_ready`: if `char_pos`=31 go to DONE, else increment `char_pos`.
  - `char_data` and `char_pos` stay stable while `char_ready`=0.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE. DONE also accepts `start` exactly like IDLE.
- Line 1 (pos 0-15): mnemonic, left-justified, space-padded.
  - Mnemonics: "LOAD", "ADD", "ADDI", "SUB", "SUBI", "MUL", "CLEAR", "DISPLAY".
- Line 2 column layout (pos = 16 + col):
  - col 0: 'R'
  - cols 1-2: `reg_idx` as two decimal digits, 00-15
  - col 3: '='
  - col 4: '-' if sign, else space
  - cols 5-9: five decimal digits, right-justified
  - cols 10-15: see Configuration
- Leading-zero blanking: digits before the first nonzero digit become spaces. Col 9 always shows a digit, so value 0 gives "    0".
- Characters are built combinationally from the latched fields and BCD; no 32-byte buffer.
- Reset: state IDLE, `char_valid`=0, `char_data`=0x00, `char_pos`=0, `busy`=0, `done`=0, BCD and latches cleared.
- Reset asserted mid-CONVERT or mid-STREAM: abort at that edge; no `done`; no further characters.
- `start` while `busy`=1: ignored, with no effect on latched operands.

## Timing

- `start` sampled at edge k:
  - `busy`=1 from k+1.
  - CONVERT occupies cycles k+1..k+16.
  - First `char_valid` in cycle k+17.
- With `char_ready` tied high:
  - One character per cycle, pos 31 accepted in cycle k+48.
  - `done`=1 and `busy`=0 in cycle k+49.
- Each cycle of `char_ready`=0 in STREAM adds exactly one cycle.
- `busy`=1 exactly in CONVERT and STREAM.
- `char_valid` is never high outside STREAM.

## Configuration

- Macro: `LCD_FMT_HEX_EN`.
- Defined: cols 11-14 show the raw latched `value` as four uppercase hex digits; col 15 = 'h'; col 10 = space.
- Not defined: cols 10-15 are spaces; hex logic is absent.
- Decimal fields and timing are identical in both builds.

## Test plan

- LOAD, `reg_idx`=3, `value`=5, ready high:
  - Line 1 = "LOAD" + 12 spaces; line 2 = "R03=     5" + 6 spaces.
  - `done` at k+49.
- SUBI, `reg_idx`=12, `value`=0xFFF6:
  - Line 2 = "R12=-   10".
  - With HEX_EN, cols 11-15 = "FFF6h".
- `value`=0x8000 → line 2 cols 4-9 "-32768".
- `value`=0 → col 9 '0', cols 5-8 spaces.
- Backpressure: drop `char_ready` for 3 cycles at pos 7:
  - `char_data`/`char_pos` held.
  - `done` delayed by exactly 3 cycles.
- Pulse `start` with different operands at k+20: output unchanged.
- Reset at k+30: all outputs at reset values next cycle and no `done`.
- A new `start` after that reset works normally.

Source files
------------

// File: rtl/lcd_line_formatter.sv
// Formats a CPU result (opcode, register, signed 16-bit value) into a 16x2 ASCII screen image and streams it one character per handshake.
// Optional build macro LCD_FMT_HEX_EN adds the raw hex value to line 2 cols 11-15.
module lcd_line_formatter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [3:0]  reg_idx,
    input  logic [15:0] value,
    input  logic        char_ready,
    output logic        char_valid,
    output logic [7:0]  char_data,
    output logic [4:0]  char_pos,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        STREAM  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [2:0]  opcode_r;
    logic [3:0]  reg_idx_r;
    logic        sign_r;
    logic [15:0] mag_r;
    logic [19:0] bcd_r;
    logic [3:0]  iter_r;
    logic [4:0]  pos_r;
    logic [7:0]  char_s;
    logic        nz4_s, nz3_s, nz2_s, nz1_s;
`ifdef LCD_FMT_HEX_EN
    logic [15:0] value_r;

    function automatic logic [7:0] hex_char(input logic [3:0] d);
        logic [7:0] c;
        if (d < 4'd10) c = 8'h30 + {4'h0, d};
        else           c = 8'h37 + {4'h0, d};
        return c;
    endfunction
`endif

    function automatic logic [19:0] dabble_adjust(input logic [19:0] bcd);
        logic [19:0] res;
        res = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else                       res[4*i +: 4] = bcd[4*i +: 4];
        end
        return res;
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    function automatic logic [7:0] mnemonic_char(input logic [2:0] op, input logic [3:0] col);
        logic [63:0] name;
        logic [63:0] shifted;
        case (op)
            3'd0:    name = "LOAD    ";
            3'd1:    name = "ADD     ";
            3'd2:    name = "ADDI    ";
            3'd3:    name = "SUB     ";
            3'd4:    name = "SUBI    ";
            3'd5:    name = "MUL     ";
            3'd6:    name = "CLEAR   ";
            3'd7:    name = "DISPLAY ";
            default: name = "        ";
        endcase
        shifted = name << {col[2:0], 3'b000};
        return col[3] ? 8'h20 : shifted[63:56];
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_next_s;
    end

    // FSM next-state logic; DONE accepts a new request just like IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    if (start) state_next_s = CONVERT; else state_next_s = IDLE;
            CONVERT: if (iter_r == 4'd15) state_next_s = STREAM; else state_next_s = CONVERT;
            STREAM:  if (char_ready && pos_r == 5'd31) state_next_s = DONE; else state_next_s = STREAM;
            DONE:    if (start) state_next_s = CONVERT; else state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand latch, double-dabble engine and character position counter
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_r  <= 3'd0;
            reg_idx_r <= 4'd0;
            sign_r    <= 1'b0;
            mag_r     <= 16'd0;
            bcd_r     <= 20'd0;
            iter_r    <= 4'd0;
            pos_r     <= 5'd0;
`ifdef LCD_FMT_HEX_EN
            value_r   <= 16'd0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        opcode_r  <= opcode;
                        reg_idx_r <= reg_idx;
                        sign_r    <= value[15];
                        // two's-complement negate wraps 0x8000 to itself, read as 32768 unsigned
                        mag_r     <= value[15] ? (16'd0 - value) : value;
                        bcd_r     <= 20'd0;
                        iter_r    <= 4'd0;
                        pos_r     <= 5'd0;
`ifdef LCD_FMT_HEX_EN
                        value_r   <= value;
`endif
                    end
                end
                CONVERT: begin
                    {bcd_r, mag_r} <= {dabble_adjust(bcd_r), mag_r} << 1;
                    iter_r         <= iter_r + 4'd1;
                    pos_r          <= 5'd0;
                end
                STREAM: begin
                    if (char_ready && pos_r != 5'd31) pos_r <= pos_r + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign nz4_s = (bcd_r[19:16] != 4'd0);
    assign nz3_s = nz4_s | (bcd_r[15:12] != 4'd0);
    assign nz2_s = nz3_s | (bcd_r[11:8] != 4'd0);
    assign nz1_s = nz2_s | (bcd_r[7:4] != 4'd0);

    // Screen character for the current position, built from latched fields and BCD
    always_comb begin
        char_s = 8'h20;
        if (!pos_r[4]) begin
            char_s = mnemonic_char(opcode_r, pos_r[3:0]);
        end else begin
            case (pos_r[3:0])
                4'd0:    char_s = 8'h52;
                4'd1:    char_s = (reg_idx_r >= 4'd10) ? 8'h31 : 8'h30;
                4'd2:    char_s = digit_char((reg_idx_r >= 4'd10) ? (reg_idx_r - 4'd10) : reg_idx_r);
                4'd3:    char_s = 8'h3D;
                4'd4:    char_s = sign_r ? 8'h2D : 8'h20;
                4'd5:    char_s = nz4_s ? digit_char(bcd_r[19:16]) : 8'h20;
                4'd6:    char_s = nz3_s ? digit_char(bcd_r[15:12]) : 8'h20;
                4'd7:    char_s = nz2_s ? digit_char(bcd_r[11:8]) : 8'h20;
                4'd8:    char_s = nz1_s ? digit_char(bcd_r[7:4]) : 8'h20;
                4'd9:    char_s = digit_char(bcd_r[3:0]);
`ifdef LCD_FMT_HEX_EN
                4'd11:   char_s = hex_char(value_r[15:12]);
                4'd12:   char_s = hex_char(value_r[11:8]);
                4'd13:   char_s = hex_char(value_r[7:4]);
                4'd14:   char_s = hex_char(value_r[3:0]);
                4'd15:   char_s = 8'h68;
`endif
                default: char_s = 8'h20;
            endcase
        end
    end

    assign char_valid = (state_r == STREAM);
    assign char_data  = char_valid ? char_s : 8'h00;
    assign char_pos   = pos_r;
    assign busy       = (state_r == CONVERT) || (state_r == STREAM);
    assign done       = (state_r == DONE);

endmodule

// File: tb/tb_lcd_line_formatter.sv
// Self-checking bench for lcd_line_formatter: table of operand vectors, scoreboard of expected characters, plus backpressure, busy-start and mid-stream reset sequences.
module tb_lcd_line_formatter;

    logic        clk = 1'b0;
    logic        reset, start, char_ready;
    logic [2:0]  opcode;
    logic [3:0]  reg_idx;
    logic [15:0] value;
    logic        char_valid, busy, done;
    logic [7:0]  char_data;
    logic [4:0]  char_pos;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  ridx;
        logic [15:0] val;
        string       mnem;
        string       l2;
        string       hx;
    } vec_t;

    typedef struct packed {
        logic [4:0] pos;
        logic [7:0] data;
    } sb_t;

    vec_t vecs[8];
    sb_t  sbq[$];

    lcd_line_formatter dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .reg_idx(reg_idx),
        .value(value), .char_ready(char_ready), .char_valid(char_valid),
        .char_data(char_data), .char_pos(char_pos), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic [2:0] op, input logic [3:0] r, input logic [15:0] v,
                           input string m, input string l2, input string hx);
        vecs[i].op = op; vecs[i].ridx = r; vecs[i].val = v;
        vecs[i].mnem = m; vecs[i].l2 = l2; vecs[i].hx = hx;
    endtask

    function automatic logic [7:0] exp_char(input vec_t v, input int p);
        int col;
        logic [7:0] ch;
        ch = 8'h20;
        col = p - 16;
        if (p < 16) begin
            if (p < v.mnem.len()) ch = v.mnem[p];
        end else if (col < 10) ch = v.l2[col];
`ifdef LCD_FMT_HEX_EN
        else if (col >= 11 && col <= 14) ch = v.hx[col-11];
        else if (col == 15) ch = 8'h68;
`endif
        return ch;
    endfunction

    // Issue one request and follow it to done; optional stall, busy-time start poke, or reset at cycle 30
    task automatic run_vec(input int idx, input int stall_at, input int stall_len, input bit poke, input bit do_reset);
        vec_t v;
        int c, stalls, first_valid, done_at;
        bit seen_bad;
        v = vecs[idx];
        sbq.delete();
        for (int p = 0; p < 32; p++) sbq.push_back('{pos: 5'(p), data: exp_char(v, p)});
        opcode = v.op; reg_idx = v.ridx; value = v.val; start = 1'b1; char_ready = 1'b1;
        step();
        start = 1'b0;
        c = 1;
        chk("busy_rise", busy, 1);
        first_valid = 0; done_at = 0; stalls = 0;
        while (c < 300 && done_at == 0) begin
            if (char_valid) begin
                if (first_valid == 0) first_valid = c;
                if (sbq.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    chk("char_pos", char_pos, sbq[0].pos);
                    chk("char_data", char_data, sbq[0].data);
                end
            end
            if (done) done_at = c;
            else begin
                char_ready = 1'b1;
                if (char_valid && char_pos == 5'(stall_at) && stalls < stall_len) begin
                    char_ready = 1'b0;
                    stalls++;
                end
                if (char_valid && char_ready && sbq.size() > 0) void'(sbq.pop_front());
                start = 1'b0;
                if (poke && c == 20) begin
                    start = 1'b1; opcode = ~v.op; reg_idx = ~v.ridx; value = ~v.val;
                end
                if (do_reset && c == 30) begin
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    chk("rst_valid", char_valid, 0);
                    chk("rst_data", char_data, 0);
                    chk("rst_pos", char_pos, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    seen_bad = 1'b0;
                    for (int n = 0; n < 60; n++) begin
                        if (char_valid || done || busy) seen_bad = 1'b1;
                        step();
                    end
                    chk("post_reset_quiet", seen_bad, 0);
                    sbq.delete();
                    return;
                end
                step();
                c++;
            end
        end
        chk("first_valid_cycle", first_valid, 17);
        chk("done_cycle", done_at, 49 + stall_len);
        chk("busy_in_done", busy, 0);
        chk("sb_empty", sbq.size(), 0);
    endtask

    initial begin
        set_vec(0, 3'd0, 4'd3,  16'h0005, "LOAD",    "R03=     5", "0005");
        set_vec(1, 3'd4, 4'd12, 16'hFFF6, "SUBI",    "R12=-   10", "FFF6");
        set_vec(2, 3'd5, 4'd15, 16'h8000, "MUL",     "R15=-32768", "8000");
        set_vec(3, 3'd6, 4'd0,  16'h0000, "CLEAR",   "R00=     0", "0000");
        set_vec(4, 3'd1, 4'd9,  16'h7FFF, "ADD",     "R09= 32767", "7FFF");
        set_vec(5, 3'd7, 4'd10, 16'hFFFF, "DISPLAY", "R10=-    1", "FFFF");
        set_vec(6, 3'd2, 4'd7,  16'h03E8, "ADDI",    "R07=  1000", "03E8");
        set_vec(7, 3'd3, 4'd1,  16'h0064, "SUB",     "R01=   100", "0064");

        reset = 1'b1; start = 1'b0; char_ready = 1'b0;
        opcode = 3'd0; reg_idx = 4'd0; value = 16'd0;
        step(); step(); step();
        reset = 1'b0;
        chk("reset_valid", char_valid, 0);
        chk("reset_data", char_data, 0);
        chk("reset_pos", char_pos, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        for (int i = 0; i < 8; i++) run_vec(i, 0, 0, 1'b0, 1'b0);
        run_vec(1, 7, 3, 1'b0, 1'b0);
        run_vec(2, 0, 0, 1'b1, 1'b0);
        step(); step();
        run_vec(3, 0, 0, 1'b0, 1'b1);
        run_vec(0, 0, 0, 1'b0, 1'b0);
        step();
        chk("idle_after_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
